screen_painter: RTL and testbench
=================================

# screen_painter

Frame painter downstream of the game-screen FSM. It watches the 2-bit screen code and, whenever that code changes or a redraw is requested, sweeps the full 160x120 frame in raster order. It drives one pixel per clock into the VGA adapter's plot port. The block owns every full-screen fill; sprite drawing (car, obstacles) runs only while it reports idle.

## Interface
- WIDTH, 160, frame width in pixels
- HEIGHT, 120, frame height in pixels
- ROAD_L, 40, first road column of the background screen
- ROAD_R, 119, last road column of the background screen
- CLOCK_50  in  1  system clock; all state on rising edge
- RESET  in  1  reset; one clock; reset is asynchronous and active-high
- SCREEN  in  2  screen code: 00 title, 01 background, 10 win, 11 lose
- REDRAW  in  1  single-cycle request to repaint the current screen
- VGA_X  out  8  pixel column
- VGA_Y  out  7  pixel row
- VGA_COLOUR  out  3  RGB colour {R,G,B}
- VGA_PLOT  out  1  pixel write strobe
- BUSY  out  1  high while a frame sweep is in progress
- DONE  out  1  single-cycle pulse after the last pixel of a frame

## Operation
- States:
  - IDLE: waits for a trigger.
  - LOAD: latches the screen code into `cur`, clears x and y.
  - PAINT: writes one pixel per cycle.
  - FIN: pulses DONE.
- Trigger, evaluated in IDLE, PAINT and FIN: SCREEN != `cur`, or REDRAW = 1. Any trigger moves the FSM to LOAD.
- After reset, `cur` = 00 and a pending flag = 1. The first cycle out of reset therefore goes to LOAD, and the title screen is painted without any external request.
- PAINT:
  - VGA_PLOT = 1; VGA_X = x, VGA_Y = y; colour is a function of (`cur`, x, y).
  - x increments each cycle. At x = WIDTH-1, x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1), the next state is FIN.
- Colour rules:
  - 00 title: 111 when x = 0, x = WIDTH-1, y = 0 or y = HEIGHT-1; else 001.
  - 01 background:
    - 010 outside [ROAD_L, ROAD_R].
    - Inside the road: 111 when x is in {79, 80} and y[3] = 0; else 000.
  - 10 win: 110 everywhere.
  - 11 lose: 100 everywhere.
- Mid-frame trigger: the sweep is abandoned and restarts at (0,0) with the new code. No DONE pulse is issued for the abandoned frame.
- REDRAW together with a SCREEN change in the same cycle: a single restart.
- FIN returns to IDLE on the next cycle unless a trigger is present.
- RESET during PAINT immediately forces:
  - VGA_PLOT = 0, BUSY = 0, DONE = 0
  - VGA_X = 0, VGA_Y = 0, VGA_COLOUR = 000
  - pending flag = 1
- Arithmetic: x is 8 bits, y is 7 bits. Comparisons are unsigned. No counter ever exceeds WIDTH-1 or HEIGHT-1.

## Timing
- Every output is registered. Reset values: VGA_X = 0, VGA_Y = 0, VGA_COLOUR = 000, VGA_PLOT = 0, BUSY = 0, DONE = 0.
- Trigger sampled at edge k → LOAD. Pixel (0,0) is presented with VGA_PLOT = 1 after edge k+1.
- A full frame is WIDTH*HEIGHT = 19200 consecutive plot cycles with no gaps.
- The last pixel is presented after edge k+19200. DONE is high for exactly the cycle after edge k+19201.
- BUSY is high from LOAD through the last PAINT cycle. BUSY is low in IDLE and FIN.
- REDRAW held high restarts the sweep every cycle. This is legal; drivers must pulse REDRAW for one cycle.

## Structure
- Shared package `screen_pkg` holds:
  - screen codes SCR_TITLE/SCR_BG/SCR_WIN/SCR_LOSE, shared with the game-screen FSM
  - colour constants (WHITE, BLUE, GREEN, BLACK, YELLOW, RED)
  - the painter state encoding
- One natural sub-module: `raster_counter`. It holds x/y with clear, enable and a last-pixel flag. The colour function stays in the top as combinational logic feeding the output registers.

## Test plan
- Reset release with SCREEN = 00 → 19200 plots. Pixel (0,0) = 111, pixel (5,5) = 001. DONE pulses once; BUSY then falls.
- SCREEN 00→01 while IDLE → sweep restarts, with these pixels:
  - (10,3) = 010
  - (79,0) = 111
  - (79,8) = 000
  - (60,20) = 000
- SCREEN 01→10 at pixel index 5000 → the next plot after LOAD is (0,0) = 110. Exactly one DONE pulse, 19200 plots after the restart.
- REDRAW pulse while IDLE with SCREEN = 11 → full frame of 100. Plot count is exactly 19200.
- RESET asserted mid-sweep, released 3 cycles later → all outputs are 0 during reset. The title repaint begins 2 cycles after release.
- Scoreboard over every frame → no gaps, no duplicate coordinates, raster order, x ≤ 159, y ≤ 119.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared definitions for the game-screen FSM and the frame painter:
// screen codes, the 3-bit RGB palette, frame geometry and painter states.
package screen_pkg;

    localparam int FRAME_W    = 160;
    localparam int FRAME_H    = 120;
    localparam int ROAD_LEFT  = 40;
    localparam int ROAD_RIGHT = 119;

    typedef enum logic [1:0] {
        SCR_TITLE = 2'b00,
        SCR_BG    = 2'b01,
        SCR_WIN   = 2'b10,
        SCR_LOSE  = 2'b11
    } screen_t;

    localparam logic [2:0] WHITE  = 3'b111;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] RED    = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAINT,
        ST_FIN
    } paint_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y pixel counter with synchronous clear and enable.
// Also exposes the following pixel so the painter can register it directly.
module raster_counter
    import screen_pkg::*;
#(
    parameter int WIDTH  = FRAME_W,
    parameter int HEIGHT = FRAME_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [7:0] x_nxt,
    output logic [6:0] y_nxt,
    output logic       last
);

    logic end_row;

    assign end_row = (x == 8'(WIDTH - 1));
    assign last    = end_row && (y == 7'(HEIGHT - 1));

    always_comb begin
        x_nxt = end_row ? 8'd0 : x + 8'd1;
        y_nxt = y;
        if (end_row) begin
            y_nxt = last ? 7'd0 : y + 7'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= 8'd0;
            y <= 7'd0;
        end else if (clr) begin
            x <= 8'd0;
            y <= 7'd0;
        end else if (en) begin
            x <= x_nxt;
            y <= y_nxt;
        end
    end

endmodule

// File: rtl/screen_painter.sv
// Full-screen painter: on a screen-code change or redraw request it sweeps the
// whole frame in raster order, one registered pixel per clock into the VGA plot port.
module screen_painter
    import screen_pkg::*;
#(
    parameter int WIDTH  = FRAME_W,
    parameter int HEIGHT = FRAME_H,
    parameter int ROAD_L = ROAD_LEFT,
    parameter int ROAD_R = ROAD_RIGHT
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [1:0] SCREEN,
    input  logic       REDRAW,
    output logic [7:0] VGA_X,
    output logic [6:0] VGA_Y,
    output logic [2:0] VGA_COLOUR,
    output logic       VGA_PLOT,
    output logic       BUSY,
    output logic       DONE
);

    localparam int LANE_L = (ROAD_L + ROAD_R) / 2;

    paint_state_t state, state_nxt;
    screen_t      cur;
    logic         pending;
    logic         trigger;
    logic         clr, en, last;
    logic [7:0]   x, x_nxt, px;
    logic [6:0]   y, y_nxt, py;
    logic [2:0]   colour;

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_raster (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .clr   (clr),
        .en    (en),
        .x     (x),
        .y     (y),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .last  (last)
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        trigger   = pending || (SCREEN != cur) || REDRAW;
        state_nxt = state;
        case (state)
            ST_IDLE:  if (trigger) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_PAINT;
            ST_PAINT: begin
                if (trigger)   state_nxt = ST_LOAD;
                else if (last) state_nxt = ST_FIN;
            end
            ST_FIN:   state_nxt = trigger ? ST_LOAD : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        clr = (state_nxt == ST_LOAD);
        en  = (state == ST_PAINT) && (state_nxt == ST_PAINT);
        // Leaving LOAD presents the cleared origin; inside PAINT present the next pixel.
        px  = (state == ST_LOAD) ? x : x_nxt;
        py  = (state == ST_LOAD) ? y : y_nxt;
    end

    always_comb begin
        colour = BLACK;
        case (cur)
            SCR_TITLE: begin
                if (px == 8'd0 || px == 8'(WIDTH - 1) || py == 7'd0 || py == 7'(HEIGHT - 1))
                    colour = WHITE;
                else
                    colour = BLUE;
            end
            SCR_BG: begin
                if (px < 8'(ROAD_L) || px > 8'(ROAD_R))
                    colour = GREEN;
                else if ((px == 8'(LANE_L) || px == 8'(LANE_L + 1)) && !py[3])
                    colour = WHITE;
                else
                    colour = BLACK;
            end
            SCR_WIN:  colour = YELLOW;
            SCR_LOSE: colour = RED;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cur        <= SCR_TITLE;
            pending    <= 1'b1;
            VGA_X      <= 8'd0;
            VGA_Y      <= 7'd0;
            VGA_COLOUR <= 3'b000;
            VGA_PLOT   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            if (state_nxt == ST_LOAD) begin
                cur     <= screen_t'(SCREEN);
                pending <= 1'b0;
            end
            VGA_PLOT <= (state_nxt == ST_PAINT);
            BUSY     <= (state_nxt == ST_LOAD) || (state_nxt == ST_PAINT);
            DONE     <= (state_nxt == ST_FIN);
            if (state_nxt == ST_PAINT) begin
                VGA_X      <= px;
                VGA_Y      <= py;
                VGA_COLOUR <= colour;
            end
        end
    end

endmodule

// File: tb/tb_screen_painter.sv
// Directed bench for screen_painter with a raster-order scoreboard running
// alongside the directed pixel, latency and reset checks.
module tb_screen_painter;

    logic       clk = 1'b0;
    logic       RESET;
    logic [1:0] SCREEN;
    logic       REDRAW;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] VGA_COLOUR;
    logic       VGA_PLOT, BUSY, DONE;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0, exp_x = 0, exp_y = 0, plot_cnt = 0, frame_plots = 0;
    int done_cnt = 0, load_cyc = 0, done_cyc = 0, seq_err = 0, col_err = 0;
    logic [1:0] exp_scr = 2'b00;
    logic [2:0] c;

    screen_painter dut (
        .CLOCK_50   (clk),
        .RESET      (RESET),
        .SCREEN     (SCREEN),
        .REDRAW     (REDRAW),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .VGA_COLOUR (VGA_COLOUR),
        .VGA_PLOT   (VGA_PLOT),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [1:0] s, input int x, input int y);
        case (s)
            2'b00: return (x == 0 || x == 159 || y == 0 || y == 119) ? 3'b111 : 3'b001;
            2'b01: begin
                if (x < 40 || x > 119) return 3'b010;
                if ((x == 79 || x == 80) && ((y / 8) % 2 == 0)) return 3'b111;
                return 3'b000;
            end
            2'b10: return 3'b110;
            default: return 3'b100;
        endcase
    endfunction

    // scoreboard: sequence, colour, per-frame plot count, DONE bookkeeping
    initial forever begin
        @(negedge clk);
        cyc++;
        if (RESET) begin
            exp_x = 0; exp_y = 0; plot_cnt = 0;
        end else begin
            if (BUSY && !VGA_PLOT) begin
                exp_x = 0; exp_y = 0; plot_cnt = 0; exp_scr = SCREEN; load_cyc = cyc;
            end
            if (VGA_PLOT) begin
                if (exp_y >= 120 || 32'(VGA_X) != exp_x || 32'(VGA_Y) != exp_y) seq_err++;
                else if (VGA_COLOUR !== model(exp_scr, exp_x, exp_y)) col_err++;
                plot_cnt++;
                exp_x++;
                if (exp_x == 160) begin exp_x = 0; exp_y++; end
            end
            if (DONE) begin
                done_cnt++; frame_plots = plot_cnt; done_cyc = cyc;
            end
        end
    end

    task automatic wait_pixel(input int x, input int y, output logic [2:0] col);
        int n = 0;
        col = 3'bxxx;
        do begin
            @(negedge clk);
            n++;
        end while (!(VGA_PLOT && 32'(VGA_X) == x && 32'(VGA_Y) == y) && n < 20000);
        if (n >= 20000) check_eq("wait_pixel_timeout", 32'(n), 32'(0));
        else col = VGA_COLOUR;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!DONE && n < 20000);
        if (n >= 20000) check_eq("wait_done_timeout", 32'(n), 32'(0));
        #1;
    endtask

    initial begin
        RESET = 1'b1; SCREEN = 2'b00; REDRAW = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", 32'({VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT, BUSY, DONE}), 32'(0));

        // title painted without any request
        RESET = 1'b0;
        @(negedge clk);
        check_eq("title_load", 32'({BUSY, VGA_PLOT}), 32'(2'b10));
        @(negedge clk);
        check_eq("title_first", 32'({VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR}), {13'd0, 1'b1, 8'd0, 7'd0, 3'b111});
        wait_pixel(5, 5, c);
        check_eq("title_5_5", 32'(c), 32'(3'b001));
        wait_done();
        check_eq("title_plots", 32'(frame_plots), 32'(19200));
        check_eq("title_latency", 32'(done_cyc - load_cyc), 32'(19201));
        check_eq("title_fin", 32'({DONE, BUSY}), 32'(2'b10));
        @(negedge clk);
        check_eq("title_idle", 32'({DONE, BUSY, VGA_PLOT}), 32'(0));
        check_eq("title_errs", 32'(seq_err + col_err), 32'(0));

        // background, abandoned at pixel index 5000 for win
        repeat (3) @(negedge clk);
        SCREEN = 2'b01;
        @(negedge clk);
        check_eq("bg_load", 32'({BUSY, VGA_PLOT}), 32'(2'b10));
        wait_pixel(79, 0, c);  check_eq("bg_79_0", 32'(c), 32'(3'b111));
        wait_pixel(10, 3, c);  check_eq("bg_10_3", 32'(c), 32'(3'b010));
        wait_pixel(79, 8, c);  check_eq("bg_79_8", 32'(c), 32'(3'b000));
        wait_pixel(60, 20, c); check_eq("bg_60_20", 32'(c), 32'(3'b000));
        wait_pixel(40, 31, c);
        SCREEN = 2'b10;
        @(negedge clk);
        check_eq("win_load", 32'({BUSY, VGA_PLOT, DONE}), 32'(3'b100));
        @(negedge clk);
        check_eq("win_first", 32'({VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR}), {13'd0, 1'b1, 8'd0, 7'd0, 3'b110});
        wait_done();
        check_eq("win_plots", 32'(frame_plots), 32'(19200));
        check_eq("win_latency", 32'(done_cyc - load_cyc), 32'(19201));
        check_eq("win_done_count", 32'(done_cnt), 32'(2));

        // lose: SCREEN change and REDRAW together give one restart
        @(negedge clk);
        SCREEN = 2'b11; REDRAW = 1'b1;
        @(negedge clk);
        REDRAW = 1'b0;
        check_eq("lose_load", 32'({BUSY, VGA_PLOT}), 32'(2'b10));
        @(negedge clk);
        check_eq("lose_first", 32'({VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR}), {13'd0, 1'b1, 8'd0, 7'd0, 3'b100});
        @(negedge clk);
        check_eq("lose_second", 32'({VGA_PLOT, VGA_X, VGA_Y}), {16'd0, 1'b1, 8'd1, 7'd0});
        wait_done();
        check_eq("lose_plots", 32'(frame_plots), 32'(19200));
        check_eq("lose_done_count", 32'(done_cnt), 32'(3));
        check_eq("lose_errs", 32'(seq_err + col_err), 32'(0));

        // REDRAW alone while idle, then reset mid-sweep
        repeat (2) @(negedge clk);
        REDRAW = 1'b1;
        @(negedge clk);
        REDRAW = 1'b0;
        check_eq("redraw_load", 32'({BUSY, VGA_PLOT}), 32'(2'b10));
        @(negedge clk);
        check_eq("redraw_first", 32'({VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR}), {13'd0, 1'b1, 8'd0, 7'd0, 3'b100});
        repeat (150) @(negedge clk);
        check_eq("redraw_mid", 32'({BUSY, VGA_PLOT, VGA_X}), {22'd0, 2'b11, 8'd150});
        RESET = 1'b1; SCREEN = 2'b00;
        #1;
        check_eq("rst_async", 32'({VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT, BUSY, DONE}), 32'(0));
        repeat (3) @(negedge clk);
        check_eq("rst_hold", 32'({VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT, BUSY, DONE}), 32'(0));
        RESET = 1'b0;
        @(negedge clk);
        check_eq("post_rst_load", 32'({BUSY, VGA_PLOT}), 32'(2'b10));
        @(negedge clk);
        check_eq("post_rst_first", 32'({VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR}), {13'd0, 1'b1, 8'd0, 7'd0, 3'b111});
        repeat (200) @(negedge clk);
        #1;
        check_eq("final_done_count", 32'(done_cnt), 32'(3));
        check_eq("final_seq_errs", 32'(seq_err), 32'(0));
        check_eq("final_col_errs", 32'(col_err), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
